dm_stage: RTL and testbench

Data-memory (DM) stage of the 5-stage MIPS pipeline: it sits between EX and WB.
- Consumes the EX/DM latch and performs LW/LH/LHU/LB/LBU/SW/SH/SB against an internal 1024-word, big-endian data memory.
- Produces the DM/WB latch and the per-cycle WB instruction word for the snapshot dump.
- Detects memory faults (address overflow, misalignment) and raises a sticky halt.

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/dm_byte_lane.sv | 57 +++++
 rtl/dm_stage.sv | 112 +++++++++++
 tb/tb_dm_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, access sizes and decode helpers
// used by the data-memory stage.
package mips_pkg;

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LHU  = 6'h25;
  localparam logic [5:0] OP_LB   = 6'h20;
  localparam logic [5:0] OP_LBU  = 6'h24;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_SH   = 6'h29;
  localparam logic [5:0] OP_SB   = 6'h28;
  localparam logic [5:0] OP_HALT = 6'h3f;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  function automatic size_e access_size(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:          return SZ_WORD;
      OP_LH, OP_LHU, OP_SH:  return SZ_HALF;
      OP_LB, OP_LBU, OP_SB:  return SZ_BYTE;
      default:               return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_signed_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dm_byte_lane.sv
// Big-endian lane logic: merges store data into the addressed lanes of a word
// and extracts/extends the addressed lanes for loads.
module dm_byte_lane
  import mips_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] merged_word,
  output logic [31:0] load_value
);

  logic [3:0]  byte_en;
  logic [31:0] store_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // byte_en[3] is offset 0, i.e. bits [31:24]
  always_comb begin
    byte_en   = 4'b0000;
    store_rep = store_data;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b1000 >> offset;
        store_rep = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        byte_en   = offset[1] ? 4'b0011 : 4'b1100;
        store_rep = {2{store_data[15:0]}};
      end
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = byte_en[gi] ? store_rep[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

  assign ld_byte = old_word[{2'd3 - offset, 3'b000} +: 8];
  assign ld_half = offset[1] ? old_word[15:0] : old_word[31:16];

  always_comb begin
    load_value = old_word;
    case (size)
      SZ_BYTE: load_value = sign_ext ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      SZ_HALF: load_value = sign_ext ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: load_value = old_word;
    endcase
  end

endmodule

// File: rtl/dm_stage.sv
// MIPS data-memory stage: big-endian data memory, load/store execution,
// fault detection and the DM/WB pipeline latch with sticky halt.
module dm_stage
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [31:0]       ex_ins,
  input  logic [31:0]       ex_alu,
  input  logic [31:0]       ex_sdata,
  input  logic [4:0]        ex_rd,
  input  logic              ex_regwrite,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [31:0]       init_data,
  output logic [31:0]       wb_ins,
  output logic [31:0]       wb_result,
  output logic [4:0]        wb_rd,
  output logic              wb_regwrite,
  output logic              err_overflow,
  output logic              err_misalign,
  output logic              halt
);

  localparam logic [32:0] MAX_BYTE = 33'(4 * DEPTH_WORDS - 1);

  logic [31:0]       mem [DEPTH_WORDS];
  logic [5:0]        opcode;
  size_e             size;
  logic              mem_op;
  logic              load_op;
  logic [32:0]       last_byte;
  logic              overflow;
  logic              misalign;
  logic              fault;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       old_word;
  logic [31:0]       merged_word;
  logic [31:0]       load_value;
  logic [31:0]       result_next;
  logic              store_en;

  assign opcode    = ex_ins[31:26];
  assign size      = access_size(opcode);
  assign mem_op    = ex_valid && (size != SZ_NONE);
  assign load_op   = is_load(opcode);
  assign last_byte = {1'b0, ex_alu} + 33'(size_bytes(size)) - 33'd1;
  assign overflow  = mem_op && (last_byte > MAX_BYTE);
  assign misalign  = mem_op && (((size == SZ_WORD) && (ex_alu[1:0] != 2'b00)) ||
                                ((size == SZ_HALF) && ex_alu[0]));
  assign fault     = overflow || misalign;
  assign word_idx  = ex_alu[ADDR_W+1:2];
  assign old_word  = mem[word_idx];

  dm_byte_lane u_lane (
    .size        (size),
    .offset      (ex_alu[1:0]),
    .sign_ext    (is_signed_load(opcode)),
    .old_word    (old_word),
    .store_data  (ex_sdata),
    .merged_word (merged_word),
    .load_value  (load_value)
  );

  // A faulting load passes the address through rather than stale array data.
  assign result_next = (mem_op && load_op && !fault) ? load_value : ex_alu;
  assign store_en    = !stall && mem_op && !load_op && !fault && !halt && !init_we;

  // Not cleared by reset; reset only blocks a write in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (rst) begin
      if (init_we) begin
        mem[init_addr] <= init_data;
      end else if (store_en) begin
        mem[word_idx] <= merged_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ins       <= NOP_WORD;
      wb_result    <= 32'h0;
      wb_rd        <= 5'd0;
      wb_regwrite  <= 1'b0;
      err_overflow <= 1'b0;
      err_misalign <= 1'b0;
      halt         <= 1'b0;
    end else if (!stall) begin
      if (ex_valid) begin
        wb_ins      <= ex_ins;
        wb_result   <= result_next;
        wb_rd       <= ex_rd;
        wb_regwrite <= ex_regwrite && !fault && !halt;
      end else begin
        wb_ins      <= NOP_WORD;
        wb_result   <= 32'h0;
        wb_rd       <= 5'd0;
        wb_regwrite <= 1'b0;
      end
      err_overflow <= err_overflow || overflow;
      err_misalign <= err_misalign || misalign;
      halt         <= halt || fault || (ex_valid && (opcode == OP_HALT));
    end
  end

endmodule

// File: tb/tb_dm_stage.sv
// Randomized and directed bench for dm_stage, checked every cycle against a
// byte-arithmetic model of the memory stage.
module tb_dm_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_ins = 32'h0;
  logic [31:0] ex_alu = 32'h0;
  logic [31:0] ex_sdata = 32'h0;
  logic [4:0]  ex_rd = 5'd0;
  logic        ex_regwrite = 1'b0;
  logic        init_we = 1'b0;
  logic [9:0]  init_addr = 10'd0;
  logic [31:0] init_data = 32'h0;
  logic [31:0] wb_ins;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        err_overflow;
  logic        err_misalign;
  logic        halt;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  always #5 clk = ~clk;

  dm_stage #(.DEPTH_WORDS(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_ins(ex_ins),
    .ex_alu(ex_alu), .ex_sdata(ex_sdata), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .wb_ins(wb_ins), .wb_result(wb_result), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .err_overflow(err_overflow), .err_misalign(err_misalign), .halt(halt)
  );

  // ---------------- reference model ----------------
  logic [31:0] mm [1024];
  logic [31:0] e_ins, e_res;
  logic [4:0]  e_rd;
  bit          e_rw, e_ovf, e_mis, e_halt;

  function automatic void model_step();
    logic [5:0]  op;
    int          n, sh;
    bit          ld, sg, ov, mi, do_st;
    logic [63:0] last;
    logic [31:0] w, r, mask, nw;
    logic [9:0]  idx;
    op = ex_ins[31:26];
    do_st = 0; nw = 0; idx = ex_alu[11:2];
    case (op)
      6'h23, 6'h2b:        n = 4;
      6'h21, 6'h25, 6'h29: n = 2;
      6'h20, 6'h24, 6'h28: n = 1;
      default:             n = 0;
    endcase
    ld = (op == 6'h23) || (op == 6'h21) || (op == 6'h25) || (op == 6'h20) || (op == 6'h24);
    sg = (op == 6'h20) || (op == 6'h21);
    if (!stall) begin
      if (!ex_valid) begin
        e_ins = 0; e_res = 0; e_rd = 0; e_rw = 0;
      end else begin
        ov = 0; mi = 0;
        if (n > 0) begin
          last = {32'h0, ex_alu} + 64'(n) - 64'd1;
          ov = last > 64'(4 * 1024 - 1);
          mi = (ex_alu % 32'(n)) != 0;
        end
        r = ex_alu;
        if (n > 0 && !ov && !mi) begin
          w    = mm[idx];
          mask = (n == 4) ? 32'hFFFF_FFFF : (n == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
          sh   = 8 * (4 - n - int'(ex_alu[1:0]));
          if (ld) begin
            r = (w >> sh) & mask;
            if (sg && n == 1 && r[7])  r = r | 32'hFFFF_FF00;
            if (sg && n == 2 && r[15]) r = r | 32'hFFFF_0000;
          end else if (!e_halt && !init_we) begin
            do_st = 1;
            nw = (w & ~(mask << sh)) | ((ex_sdata & mask) << sh);
          end
        end
        e_ins = ex_ins; e_res = r; e_rd = ex_rd;
        e_rw  = ex_regwrite && !ov && !mi && !e_halt;
        e_ovf = e_ovf | ov;
        e_mis = e_mis | mi;
        e_halt = e_halt | ov | mi | (op == 6'h3f);
      end
    end
    if (init_we) mm[init_addr] = init_data;
    if (do_st)   mm[idx] = nw;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_ins = 0; e_res = 0; e_rd = 0; e_rw = 0; e_ovf = 0; e_mis = 0; e_halt = 0;
    end else begin
      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every negedge, outputs against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("wb_ins", wb_ins, e_ins);
      chk("wb_result", wb_result, e_res);
      chk("wb_rd", 32'(wb_rd), 32'(e_rd));
      chk("wb_regwrite", 32'(wb_regwrite), 32'(e_rw));
      chk("err_overflow", 32'(err_overflow), 32'(e_ovf));
      chk("err_misalign", 32'(err_misalign), 32'(e_mis));
      chk("halt", 32'(halt), 32'(e_halt));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd);
    return {op, 5'd0, rd, 16'h1234};
  endfunction

  // Inputs change 2 time units after the posedge; returns once the op is latched.
  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                       input logic st);
    ex_valid = 1; ex_ins = ins; ex_alu = alu; ex_sdata = sd; ex_rd = rd;
    ex_regwrite = rw; stall = st;
    @(posedge clk); #2;
    ex_valid = 0; stall = 0; ex_regwrite = 0;
    $display("txn %s ins=%h alu=%h sdata=%h stall=%0d -> wb_result=%h rw=%0d halt=%0d",
             tag, ins, alu, sd, st, wb_result, wb_regwrite, halt);
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    chk("reset_wb_ins", wb_ins, 32'h0);
    chk("reset_halt", 32'(halt), 32'h0);
    @(posedge clk); #2;
    rst = 1;
  endtask

  logic [5:0] op_tab [11];
  initial begin
    op_tab[0] = 6'h23; op_tab[1] = 6'h21; op_tab[2] = 6'h25; op_tab[3] = 6'h20;
    op_tab[4] = 6'h24; op_tab[5] = 6'h2b; op_tab[6] = 6'h29; op_tab[7] = 6'h28;
    op_tab[8] = 6'h00; op_tab[9] = 6'h0d; op_tab[10] = 6'h3f;
  end

  // ---------------- main sequence ----------------
  initial begin
    int halt_age;
    #1 rst = 0;
    #1;
    check_en = 1;
    chk("rst_wb_result", wb_result, 32'h0);
    chk("rst_wb_regwrite", 32'(wb_regwrite), 32'h0);
    chk("rst_err_overflow", 32'(err_overflow), 32'h0);
    @(posedge clk); #2;
    rst = 1;

    for (int i = 0; i < 1024; i++) begin
      init_we = 1; init_addr = 10'(i);
      case (i)
        0:       init_data = 32'hA5A5_A5A5;
        2:       init_data = 32'h1122_3344;
        1, 4, 5: init_data = 32'h0;
        1023:    init_data = 32'h0BAD_F00D;
        default: init_data = $urandom;
      endcase
      @(posedge clk); #2;
    end
    init_we = 0;

    issue("LW8", mk(6'h23, 5'd1), 32'h8, 32'h0, 5'd1, 1, 0);
    chk("lw_8", wb_result, 32'h1122_3344);
    issue("LB9", mk(6'h20, 5'd2), 32'h9, 32'h0, 5'd2, 1, 0);
    chk("lb_9", wb_result, 32'h0000_0022);
    issue("LHA", mk(6'h21, 5'd3), 32'hA, 32'h0, 5'd3, 1, 0);
    chk("lh_a", wb_result, 32'h0000_3344);

    issue("SB4", mk(6'h28, 5'd0), 32'h4, 32'h0000_0080, 5'd0, 0, 0);
    issue("LB4", mk(6'h20, 5'd4), 32'h4, 32'h0, 5'd4, 1, 0);
    chk("lb_4", wb_result, 32'hFFFF_FF80);
    issue("LBU4", mk(6'h24, 5'd4), 32'h4, 32'h0, 5'd4, 1, 0);
    chk("lbu_4", wb_result, 32'h0000_0080);
    issue("LW4", mk(6'h23, 5'd4), 32'h4, 32'h0, 5'd4, 1, 0);
    chk("lw_4", wb_result, 32'h8000_0000);

    issue("SW10s", mk(6'h2b, 5'd0), 32'h10, 32'hDEAD_BEEF, 5'd0, 0, 1);
    chk("stall_hold_result", wb_result, 32'h8000_0000);
    chk("stall_hold_rd", 32'(wb_rd), 32'd4);
    issue("SW10", mk(6'h2b, 5'd0), 32'h10, 32'hDEAD_BEEF, 5'd0, 0, 0);
    issue("LW10", mk(6'h23, 5'd5), 32'h10, 32'h0, 5'd5, 1, 0);
    chk("lw_10", wb_result, 32'hDEAD_BEEF);

    init_we = 1; init_addr = 10'd5; init_data = 32'hCAFE_F00D;
    issue("SW14i", mk(6'h2b, 5'd0), 32'h14, 32'h1234_5678, 5'd0, 0, 0);
    init_we = 0;
    issue("LW14", mk(6'h23, 5'd6), 32'h14, 32'h0, 5'd6, 1, 0);
    chk("init_priority", wb_result, 32'hCAFE_F00D);

    issue("LWFFC", mk(6'h23, 5'd7), 32'hFFC, 32'h0, 5'd7, 1, 0);
    chk("lw_ffc", wb_result, 32'h0BAD_F00D);
    chk("lw_ffc_ovf", 32'(err_overflow), 32'h0);

    issue("SH1", mk(6'h29, 5'd0), 32'h1, 32'hFFFF, 5'd0, 0, 0);
    chk("sh1_misalign", 32'(err_misalign), 32'h1);
    chk("sh1_overflow", 32'(err_overflow), 32'h0);
    chk("sh1_halt", 32'(halt), 32'h1);
    issue("SW0h", mk(6'h2b, 5'd0), 32'h0, 32'hFFFF_FFFF, 5'd0, 0, 0);
    issue("LW8h", mk(6'h23, 5'd8), 32'h8, 32'h0, 5'd8, 1, 0);
    chk("halted_regwrite", 32'(wb_regwrite), 32'h0);
    do_reset();
    issue("LW0", mk(6'h23, 5'd9), 32'h0, 32'h0, 5'd9, 1, 0);
    chk("word0_intact", wb_result, 32'hA5A5_A5A5);

    issue("LWFFD", mk(6'h23, 5'd10), 32'hFFD, 32'h0, 5'd10, 1, 0);
    chk("ffd_overflow", 32'(err_overflow), 32'h1);
    chk("ffd_misalign", 32'(err_misalign), 32'h1);
    chk("ffd_regwrite", 32'(wb_regwrite), 32'h0);
    do_reset();
    issue("SB1000", mk(6'h28, 5'd0), 32'h1000, 32'h55, 5'd0, 0, 0);
    chk("sb1000_overflow", 32'(err_overflow), 32'h1);
    chk("sb1000_misalign", 32'(err_misalign), 32'h0);
    do_reset();

    issue("HALT", 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 0, 0);
    chk("halt_ins", wb_ins, 32'hFFFF_FFFF);
    chk("halt_flag", 32'(halt), 32'h1);
    issue("ADDh", mk(6'h00, 5'd11), 32'h77, 32'h0, 5'd11, 1, 0);
    chk("halt_advances", wb_ins, mk(6'h00, 5'd11));
    rst = 0;
    #1;
    chk("async_rst_ins", wb_ins, 32'h0);
    chk("async_rst_result", wb_result, 32'h0);
    chk("async_rst_halt", 32'(halt), 32'h0);
    @(posedge clk); #2;
    rst = 1;
    issue("LW8r", mk(6'h23, 5'd1), 32'h8, 32'h0, 5'd1, 1, 0);
    chk("retained_after_rst", wb_result, 32'h1122_3344);

    // randomized stream
    halt_age = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [5:0] op;
      int n, pick;
      if (e_halt) halt_age++;
      if (halt_age > 6) begin
        halt_age = 0;
        do_reset();
      end
      pick = ($urandom_range(0, 99) == 0) ? 10 : $urandom_range(0, 9);
      op = op_tab[pick];
      n = (pick == 0 || pick == 5) ? 4 : (pick == 1 || pick == 2 || pick == 6) ? 2 :
          (pick == 3 || pick == 4 || pick == 7) ? 1 : 0;
      ex_valid = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 9) == 0);
      ex_rd = 5'($urandom);
      ex_ins = (pick == 10) ? 32'hFC00_0000 : {op, 26'($urandom)};
      ex_sdata = $urandom;
      ex_regwrite = (pick >= 5 && pick <= 7) ? 1'b0 : 1'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        ex_alu = ($urandom_range(0, 1) == 0) ? $urandom : 32'(32'hFF8 + $urandom_range(0, 15));
      end else begin
        logic [31:0] widx, off;
        widx = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 1023));
        off = (n == 4 || n == 0) ? 0 : (n == 2) ? 32'(2 * $urandom_range(0, 1)) : 32'($urandom_range(0, 3));
        ex_alu = widx * 4 + off;
      end
      @(posedge clk); #2;
    end
    ex_valid = 0; stall = 0;
    @(posedge clk); #2;
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
